uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (cores); legal range 2..8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: idle cycles before a held lock is revoked; legal range 2..65535.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ: requester i offers a byte.
REQ-006 SHALL have port req_data, input, NUM_REQ*8: byte of requester i, at bits [8i+7:8i].
REQ-007 SHALL have port req_last, input, NUM_REQ: offered byte ends requester i's message.
REQ-008 SHALL have port req_ready, output, NUM_REQ: byte of requester i accepted this cycle.
REQ-009 SHALL have port tx_byte, output, 8: byte to the UART TX FIFO.
REQ-010 SHALL have port tx_transmit, output, 1: one-cycle write strobe to the UART TX FIFO.
REQ-011 SHALL have port tx_fifo_full, input, 1: UART TX FIFO cannot accept a byte.
REQ-012 SHALL have port owner, output, 3: index of the current lock holder; valid when locked is 1.
REQ-013 SHALL have port locked, output, 1: a requester holds the UART.

Function
REQ-014 SHALL implement states IDLE and LOCKED.
REQ-015 In IDLE with any req_valid set, SHALL grant by round-robin starting at (last owner + 1) mod NUM_REQ, set owner, and enter LOCKED next cycle.
REQ-016 In IDLE, SHALL drive req_ready to all zeros; first accept occurs no earlier than the cycle after the grant.
REQ-017 In LOCKED, SHALL set req_ready[owner] = req_valid[owner] & !tx_fifo_full & !tx_transmit; all other req_ready bits 0.
REQ-018 On accept, SHALL register req_data[owner] into tx_byte and pulse tx_transmit for exactly the next cycle; max throughput is one byte per 2 cycles.
REQ-019 SHALL hold tx_byte stable until the next accept.
REQ-020 On accept with req_last[owner]=1, SHALL return to IDLE next cycle and record owner as the round-robin pointer.
REQ-021 SHALL ignore req_valid, req_data and req_last of non-owners while LOCKED; their bytes are never forwarded.
REQ-022 If tx_fifo_full rises, SHALL stall with no accept, no byte loss and no duplication; the lock is kept.
REQ-023 If the owner drops req_valid mid-message, SHALL keep the lock (subject to REQ-030).
REQ-024 If a request and a release occur in the same cycle, SHALL complete the release first; the new grant is evaluated in IDLE on the following cycle.

Reset
REQ-025 While reset is low, SHALL force state IDLE, locked=0, owner=0, round-robin pointer=NUM_REQ-1 (so requester 0 wins first), tx_transmit=0, tx_byte=8'h00, req_ready=0, and the timeout counter to 0.
REQ-026 Reset asserted mid-message SHALL abandon the message; no tx_transmit pulse after reset is asserted.
REQ-027 SHALL release reset without glitches on tx_transmit; first possible grant is on the first clk edge after deassertion.

Configuration
REQ-028 Macro UART_ARB_TIMEOUT_EN SHALL enable the lock timeout.
REQ-029 Without UART_ARB_TIMEOUT_EN, the lock SHALL be released only by an accepted req_last byte or by reset.
REQ-030 With UART_ARB_TIMEOUT_EN, in LOCKED a 16-bit counter SHALL count cycles with req_valid[owner]=0, clear on owner valid, and force IDLE with the pointer advanced when the count reaches TIMEOUT_CYCLES; it SHALL saturate and SHALL NOT count while tx_fifo_full is 1.

Structure
REQ-031 SHALL place state encodings (IDLE=0, LOCKED=1) and the 16-bit timeout counter width in shared package uart_arb_pkg.
REQ-032 SHALL instantiate one sub-module rr_arbiter: combinational NUM_REQ-way round-robin picker (request vector and pointer in, one-hot grant and index out).

Verification
REQ-033 Single requester: req 2 sends 'H','i','\n'(last) -> tx_byte 8'h48, 8'h69, 8'h0A on 3 tx_transmit pulses, 2 cycles apart; then locked=0.
REQ-034 Contention: reqs 0 and 1 each send 4-byte messages together -> all 4 bytes of req 0 appear before any of req 1; no interleaving.
REQ-035 Fairness: all 4 requesters continuously send 1-byte messages -> grant order 0,1,2,3,0,...
REQ-036 Backpressure: tx_fifo_full held 10 cycles mid-message -> no tx_transmit during the stall; byte sequence unchanged after release.
REQ-037 Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): owner 1 idles after 1 byte with req 3 pending -> locked drops after 8 cycles; owner becomes 3.
REQ-038 Reset mid-message: reset low during byte 2 of 5 -> outputs take the REQ-025 values; after release, requester 0 wins first.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
//   Shared definitions for the UART TX arbiter:
//     arb_state_e    - arbiter FSM encoding (IDLE = 0, LOCKED = 1)
//     TIMEOUT_CNT_W  - width of the idle/timeout counter (16 bits)
//     IDX_W          - width of a requester index (up to 8 requesters)
// -----------------------------------------------------------------------------
package uart_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int TIMEOUT_CNT_W = 16;
    localparam int IDX_W         = 3;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational NUM_REQ-way round-robin picker. The search starts at
//   (ptr + 1) mod NUM_REQ and returns the first requester found.
//   Ports:
//     req       in  [NUM_REQ-1:0]  request vector
//     ptr       in  [IDX_W-1:0]    index of the last winner
//     grant     out [NUM_REQ-1:0]  one-hot grant (all zero when no request)
//     grant_idx out [IDX_W-1:0]    index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    // Rotating a doubled copy puts requester (ptr+1) mod NUM_REQ at bit 0,
    // so a fixed-priority scan of the rotated vector is round-robin.
    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;
    logic                 found;

    assign doubled = {req, req};
    assign rotated = NUM_REQ'(doubled >> (int'(ptr) + 1));

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && rotated[j]) begin
                found     = 1'b1;
                grant_idx = IDX_W'((int'(ptr) + 1 + j) % NUM_REQ);
            end
        end
        if (found) begin
            grant = NUM_REQ'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART TX FIFO between NUM_REQ requesters. A requester is granted
//   a lock (round-robin) and keeps it until it hands over a byte flagged last.
//   Bytes are forwarded at most one every two cycles: an accept registers the
//   byte into tx_byte and pulses tx_transmit in the following cycle.
//
//   Optional feature: define UART_ARB_TIMEOUT_EN to revoke a lock whose owner
//   has offered nothing for TIMEOUT_CYCLES cycles (not counted while the FIFO
//   is full).
//
//   Ports:
//     clk           in   clock, rising edge
//     reset         in   asynchronous, active-low reset
//     req_valid     in   [NUM_REQ]    requester i offers a byte
//     req_data      in   [NUM_REQ*8]  byte of requester i at [8i+7:8i]
//     req_last      in   [NUM_REQ]    offered byte ends requester i's message
//     req_ready     out  [NUM_REQ]    byte of requester i accepted this cycle
//     tx_byte       out  [8]          byte to the UART TX FIFO
//     tx_transmit   out               one-cycle FIFO write strobe
//     tx_fifo_full  in                FIFO cannot take a byte
//     owner         out  [3]          current lock holder (valid when locked)
//     locked        out               a requester holds the UART; this is
//                                     also the FSM state (LOCKED when 1)
//
//   Handshake: a byte of requester i moves when req_valid[i] && req_ready[i]
//   in the same cycle; req_ready never depends on anything but the owner's
//   req_valid, tx_fifo_full and the registered tx_transmit.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_byte,
    output logic                 tx_transmit,
    input  logic                 tx_fifo_full,
    output logic [2:0]           owner,
    output logic                 locked
);

    arb_state_e         state;
    arb_state_e         state_next;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;

    logic               owner_valid;
    logic               owner_last;
    logic [7:0]         owner_data;
    logic               accept;
    logic               release_lock;
    logic               timeout_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign grant_any = |grant;

    // Select the owner's request lines; everyone else is ignored.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IDX_W'(i)) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                owner_data  = req_data[8*i +: 8];
            end
        end
    end

    // No accept while the previous byte is being strobed: this is what caps
    // throughput at one byte per two cycles.
    assign accept       = (state == LOCKED) && owner_valid && !tx_fifo_full && !tx_transmit;
    assign release_lock = (state == LOCKED) && ((accept && owner_last) || timeout_hit);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A release always lands in IDLE first; a waiting request is granted
    // from IDLE on the following cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any)    state_next = LOCKED;
            LOCKED:  if (release_lock) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        locked    = (state == LOCKED);
        req_ready = '0;
        if (accept) begin
            req_ready = NUM_REQ'(1) << owner;
        end
    end

    // ---------------------------------------------------- owner / pointer
    // Pointer resets to NUM_REQ-1 so requester 0 is the first winner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner  <= '0;
            rr_ptr <= IDX_W'(NUM_REQ - 1);
        end else begin
            if (state == IDLE && grant_any) begin
                owner <= grant_idx;
            end
            if (release_lock) begin
                rr_ptr <= owner;
            end
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_transmit <= 1'b0;
            tx_byte     <= 8'h00;
        end else begin
            tx_transmit <= accept;
            if (accept) begin
                tx_byte <= owner_data;
            end
        end
    end

    // ------------------------------------------------------------- timeout
`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_CNT_W'(TIMEOUT_CYCLES);

    logic [TIMEOUT_CNT_W-1:0] idle_cnt;
    logic                     idle_count_en;

    // Counts owner-idle cycles; a full FIFO freezes the count.
    assign idle_count_en = (state == LOCKED) && !owner_valid && !tx_fifo_full;
    // Fires on the cycle the count would reach the limit, so the lock is
    // gone after exactly TIMEOUT_CYCLES idle cycles.
    assign timeout_hit   = idle_count_en && ((idle_cnt + 16'd1) == TIMEOUT_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (state != LOCKED || owner_valid || release_lock) begin
            idle_cnt <= '0;
        end else if (idle_count_en && idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=8).
//   A transaction-level model (lock holder, round-robin pointer, pending
//   strobe, idle count) predicts every output each cycle; an expected-byte
//   queue and literal checks on the logged byte/owner order pin the model.
//   Build with UART_ARB_TIMEOUT_EN to exercise the lock timeout.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    // ------------------------------------------------- clock / reset / DUT
    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_byte;
    logic           tx_transmit;
    logic           tx_fifo_full;
    logic [2:0]     owner;
    logic           locked;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_byte      (tx_byte),
        .tx_transmit  (tx_transmit),
        .tx_fifo_full (tx_fifo_full),
        .owner        (owner),
        .locked       (locked)
    );

    // ----------------------------------------------------------- counters
    int n_cmp = 0;
    int n_err = 0;

    function void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------- requester sources
    logic [7:0] src_data [N][64];
    logic       src_last [N][64];
    int         src_head [N];
    int         src_tail [N];
    logic       src_en   [N];

    function void flush_all();
        for (int i = 0; i < N; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
            src_en[i]   = 1'b1;
        end
    endfunction

    function void push_byte(int r, logic [7:0] b, logic last);
        src_data[r][src_tail[r]] = b;
        src_last[r][src_tail[r]] = last;
        src_tail[r]++;
    endfunction

    // Idle lanes carry random data/last to show the DUT ignores them.
    function void drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (src_head[i] < src_tail[i]) begin
                req_valid[i]       = src_en[i];
                req_data[8*i +: 8] = src_data[i][src_head[i]];
                req_last[i]        = src_last[i][src_head[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'($urandom_range(0, 255));
                req_last[i]        = 1'($urandom_range(0, 1));
            end
        end
    endfunction

    function bit all_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (src_head[i] < src_tail[i]) e = 1'b0;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        drive_inputs();
    end

    // ---------------------------------------------------- model + compare
    logic [7:0] exp_q[$];
    logic [7:0] tx_log[$];
    int         own_log[$];
    int         tx_cyc[$];
    int         cyc = 0;

    bit         m_locked;
    int         m_owner;
    int         m_ptr;
    bit         m_tx;
    int         m_tx_src;
    logic [7:0] m_byte;
    int         m_idle;
    logic [N-1:0] m_ready;
    bit         m_acc;
    bit         m_found;
    int         m_cand;
    logic [7:0] m_want;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            check("rst_locked", locked, 0);
            check("rst_owner", owner, 0);
            check("rst_tx_transmit", tx_transmit, 0);
            check("rst_tx_byte", tx_byte, 8'h00);
            check("rst_req_ready", req_ready, 0);
            m_locked = 1'b0;
            m_owner  = 0;
            m_ptr    = N - 1;
            m_tx     = 1'b0;
            m_tx_src = 0;
            m_byte   = 8'h00;
            m_idle   = 0;
            exp_q.delete();
        end else begin
            m_ready = '0;
            if (m_locked && req_valid[m_owner] && !tx_fifo_full && !m_tx) m_ready[m_owner] = 1'b1;
            check("req_ready", req_ready, m_ready);
            check("locked", locked, m_locked);
            if (m_locked) check("owner", owner, m_owner);
            check("tx_transmit", tx_transmit, m_tx);
            check("tx_byte", tx_byte, m_byte);
            if (m_tx) begin
                tx_log.push_back(tx_byte);
                own_log.push_back(m_tx_src);
                tx_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", tx_byte, 32'hFFFF_FFFF);
                end else begin
                    m_want = exp_q.pop_front();
                    check("scoreboard_byte", tx_byte, m_want);
                end
            end

            // Next cycle's view.
            m_acc = (m_ready != 0);
            m_tx  = m_acc;
            if (m_acc) begin
                m_byte   = req_data[8*m_owner +: 8];
                m_tx_src = m_owner;
                src_head[m_owner]++;
            end
            if (!m_locked) begin
                m_found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    m_cand = (m_ptr + k) % N;
                    if (!m_found && req_valid[m_cand]) begin
                        m_found  = 1'b1;
                        m_locked = 1'b1;
                        m_owner  = m_cand;
                        m_idle   = 0;
                    end
                end
            end else if (m_acc && req_last[m_owner]) begin
                m_locked = 1'b0;
                m_ptr    = m_owner;
                m_idle   = 0;
            end else begin
`ifdef UART_ARB_TIMEOUT_EN
                if (req_valid[m_owner]) begin
                    m_idle = 0;
                end else if (!tx_fifo_full) begin
                    if (m_idle < 65535) m_idle++;
                    if (m_idle == TO) begin
                        m_locked = 1'b0;
                        m_ptr    = m_owner;
                        m_idle   = 0;
                    end
                end
`endif
            end
        end
    end

    // ------------------------------------------------------ driver tasks
    task automatic step(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        tx_log.delete();
        own_log.delete();
        tx_cyc.delete();
    endtask

    task automatic wait_quiet(string name, int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (!locked && !tx_transmit && all_empty()) begin
                done = 1'b1;
                break;
            end
        end
        check(name, done, 1);
        step(1);
    endtask

    task automatic wait_log(string name, int n, int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (tx_log.size() >= n) begin
                done = 1'b1;
                break;
            end
        end
        check(name, done, 1);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        flush_all();
        drive_inputs();
        step(3);
        reset = 1'b1;
        step(1);
    endtask

    // --------------------------------------------------------- sequences
    int n_before;
    int lock_cycles;

    initial begin
        reset        = 1'b1;
        tx_fifo_full = 1'b0;
        flush_all();
        drive_inputs();
        #1 reset = 1'b0;
        step(3);
        reset = 1'b1;
        step(1);

        // Single requester: "Hi\n" from requester 2.
        clear_logs();
        push_byte(2, 8'h48, 1'b0);
        push_byte(2, 8'h69, 1'b0);
        push_byte(2, 8'h0A, 1'b1);
        exp_q.push_back(8'h48); exp_q.push_back(8'h69); exp_q.push_back(8'h0A);
        drive_inputs();
        wait_quiet("single_done", 40);
        check("single_count", tx_log.size(), 3);
        if (tx_log.size() == 3) begin
            check("single_b0", tx_log[0], 8'h48);
            check("single_b1", tx_log[1], 8'h69);
            check("single_b2", tx_log[2], 8'h0A);
            check("single_gap0", tx_cyc[1] - tx_cyc[0], 2);
            check("single_gap1", tx_cyc[2] - tx_cyc[1], 2);
            check("single_owner", own_log[0], 2);
        end
        check("single_unlocked", locked, 0);

        // Contention: requesters 0 and 1, 4 bytes each, no interleave.
        clear_logs();
        for (int b = 0; b < 4; b++) begin
            push_byte(0, 8'h10 + 8'(b), b == 3);
            push_byte(1, 8'h20 + 8'(b), b == 3);
        end
        for (int b = 0; b < 4; b++) exp_q.push_back(8'h10 + 8'(b));
        for (int b = 0; b < 4; b++) exp_q.push_back(8'h20 + 8'(b));
        drive_inputs();
        wait_quiet("contend_done", 80);
        check("contend_count", tx_log.size(), 8);
        if (tx_log.size() == 8) begin
            check("contend_b3", tx_log[3], 8'h13);
            check("contend_b4", tx_log[4], 8'h20);
        end

        // Fairness: every requester keeps sending 1-byte messages.
        apply_reset();
        clear_logs();
        for (int i = 0; i < N; i++) begin
            push_byte(i, 8'hA0 + 8'(i), 1'b1);
            push_byte(i, 8'hB0 + 8'(i), 1'b1);
        end
        for (int i = 0; i < N; i++) exp_q.push_back(8'hA0 + 8'(i));
        for (int i = 0; i < N; i++) exp_q.push_back(8'hB0 + 8'(i));
        drive_inputs();
        wait_quiet("fair_done", 120);
        check("fair_count", own_log.size(), 8);
        if (own_log.size() == 8) begin
            for (int k = 0; k < 8; k++) check("fair_order", own_log[k], k % 4);
        end

        // Backpressure: FIFO full for 10 cycles after the second byte.
        clear_logs();
        for (int b = 0; b < 6; b++) begin
            push_byte(3, 8'h30 + 8'(b), b == 5);
            exp_q.push_back(8'h30 + 8'(b));
        end
        drive_inputs();
        wait_log("bp_first_two", 2, 40);
        @(posedge clk);
        #2;
        tx_fifo_full = 1'b1;
        n_before = tx_log.size();
        step(10);
        check("bp_stalled", tx_log.size() - n_before, 0);
        check("bp_lock_kept", locked, 1);
        tx_fifo_full = 1'b0;
        wait_quiet("bp_done", 60);
        check("bp_count", tx_log.size(), 6);
        if (tx_log.size() == 6) check("bp_b5", tx_log[5], 8'h35);

`ifdef UART_ARB_TIMEOUT_EN
        // Timeout: owner 1 sends one byte and goes quiet; requester 3 waits.
        apply_reset();
        clear_logs();
        push_byte(1, 8'h5A, 1'b0);
        push_byte(3, 8'h3C, 1'b1);
        exp_q.push_back(8'h5A); exp_q.push_back(8'h3C);
        drive_inputs();
        wait_log("to_first", 1, 20);
        lock_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!locked) break;
            lock_cycles++;
            @(negedge clk);
            #1;
        end
        check("to_lock_cycles", lock_cycles, TO);
        @(negedge clk);
        #1;
        check("to_new_locked", locked, 1);
        check("to_new_owner", owner, 3);
        wait_quiet("to_done", 40);
        check("to_count", tx_log.size(), 2);
`else
        // Owner goes quiet mid-message: lock must persist.
        clear_logs();
        push_byte(2, 8'h55, 1'b0);
        exp_q.push_back(8'h55);
        drive_inputs();
        wait_log("hold_first", 1, 20);
        step(20);
        check("hold_locked", locked, 1);
        check("hold_owner", owner, 2);
        push_byte(2, 8'h66, 1'b1);
        push_byte(0, 8'h77, 1'b1);
        exp_q.push_back(8'h66); exp_q.push_back(8'h77);
        drive_inputs();
        wait_quiet("hold_done", 40);
        check("hold_count", tx_log.size(), 3);
        if (tx_log.size() == 3) check("hold_b2", tx_log[2], 8'h77);
`endif

        // Reset during byte 2 of 5 from requester 1.
        clear_logs();
        for (int b = 0; b < 5; b++) begin
            push_byte(1, 8'h81 + 8'(b), b == 4);
            exp_q.push_back(8'h81 + 8'(b));
        end
        drive_inputs();
        wait_log("rst_first", 1, 20);
        @(posedge clk);
        #2;
        reset = 1'b0;
        flush_all();
        push_byte(0, 8'h90, 1'b1);
        push_byte(1, 8'h91, 1'b1);
        drive_inputs();
        step(3);
        check("rst_abandoned", tx_log.size(), 1);
        reset = 1'b1;
        exp_q.push_back(8'h90); exp_q.push_back(8'h91);
        @(negedge clk);
        #1;
        check("rst_rel_idle", locked, 0);
        @(negedge clk);
        #1;
        check("rst_rel_locked", locked, 1);
        check("rst_rel_owner", owner, 0);
        wait_quiet("rst_done", 40);
        check("rst_count", tx_log.size(), 3);
        if (tx_log.size() == 3) check("rst_b1", tx_log[1], 8'h90);

        step(4);
        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
